// File: rtl/normaliser_ctrl_if.sv
// Handshake bundle between the adder datapath, the normaliser and the rounding stage.
// master drives the request side and consumes results; slave is the normaliser.
interface normaliser_ctrl_if #(
  parameter int IN_SIZE = 50,
  parameter int EXP_W   = 11
);
  logic               in_valid;
  logic               in_ready;
  logic [IN_SIZE-1:0] in_mant;
  logic [EXP_W-1:0]   in_exp;
  logic               out_valid;
  logic               out_ready;
  logic [IN_SIZE-1:0] out_mant;
  logic [EXP_W-1:0]   out_exp;
  logic               out_zero;
  logic               out_uflow;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow
  );
endinterface

// File: rtl/normaliser_ctrl.sv
// Normaliser: shifts the leading 1 to the MSB in STEP-bit chunks, adjusting the exponent (optional NORM_PERF_CNT_EN counters).
// Latency 1 + ceil(shift/STEP) cycles from accept to out_valid; one transaction in flight.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.

module counter_leading_1 #(
  parameter int IN_SIZE = 50,
  parameter int POS_W   = $clog2(IN_SIZE)
) (
  input  logic [IN_SIZE-1:0] in_vec,
  output logic [POS_W-1:0]   pos,
  output logic               zero
);
  always_comb begin
    pos = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      if (in_vec[i]) pos = POS_W'(i);
    end
  end

  assign zero = ~|in_vec;
endmodule

module normaliser_ctrl #(
  parameter int IN_SIZE = 50,
  parameter int EXP_W   = 11,
  parameter int STEP    = 8,
  parameter int POS_W   = $clog2(IN_SIZE)
) (
  input  logic        clk,
  input  logic        rst,
`ifdef NORM_PERF_CNT_EN
  output logic [15:0] perf_ops,
  output logic [15:0] perf_shift_cyc,
`endif
  normaliser_ctrl_if.slave bus
);
  localparam int RW = POS_W + 1;
  localparam int CW = (EXP_W > RW) ? EXP_W : RW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IN_SIZE-1:0] mant_q, mant_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               zero_q, zero_d;
  logic               uflow_q, uflow_d;

  logic [POS_W-1:0]   lead_pos;
  logic               lead_zero;
  logic [RW-1:0]      s_full;
  logic               s_uflow;
  logic [RW-1:0]      s_eff;
  logic [EXP_W-1:0]   exp_fin;
  logic [RW-1:0]      step_amt;

  counter_leading_1 #(.IN_SIZE(IN_SIZE), .POS_W(POS_W)) u_lead (
    .in_vec (bus.in_mant),
    .pos    (lead_pos),
    .zero   (lead_zero)
  );

  // The exponent caps the shift: a denormal result keeps exponent 0.
  assign s_full   = RW'(IN_SIZE - 1) - RW'(lead_pos);
  assign s_uflow  = CW'(bus.in_exp) < CW'(s_full);
  assign s_eff    = s_uflow ? RW'(bus.in_exp) : s_full;
  assign exp_fin  = s_uflow ? '0 : bus.in_exp - EXP_W'(s_full);
  assign step_amt = (rem_q < RW'(STEP)) ? rem_q : RW'(STEP);

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    rem_d   = rem_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    uflow_d = uflow_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (lead_zero) begin
            mant_d  = '0;
            rem_d   = '0;
            exp_d   = '0;
            zero_d  = 1'b1;
            uflow_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            mant_d  = bus.in_mant;
            rem_d   = s_eff;
            exp_d   = exp_fin;
            zero_d  = 1'b0;
            uflow_d = s_uflow;
            state_d = (s_eff == '0) ? ST_DONE : ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        mant_d = mant_q << step_amt;
        rem_d  = rem_q - step_amt;
        if (rem_q == step_amt) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mant_q  <= '0;
      rem_q   <= '0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      rem_q   <= rem_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
      uflow_q <= uflow_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_mant  = mant_q;
  assign bus.out_exp   = exp_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_uflow = uflow_q;

`ifdef NORM_PERF_CNT_EN
  logic [15:0] perf_ops_q, perf_ops_d;
  logic [15:0] perf_shift_cyc_q, perf_shift_cyc_d;

  always_comb begin
    perf_ops_d       = perf_ops_q;
    perf_shift_cyc_d = perf_shift_cyc_q;
    if (bus.out_valid && bus.out_ready && perf_ops_q != 16'hFFFF)
      perf_ops_d = perf_ops_q + 16'd1;
    if (state_q == ST_SHIFT && perf_shift_cyc_q != 16'hFFFF)
      perf_shift_cyc_d = perf_shift_cyc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q       <= '0;
      perf_shift_cyc_q <= '0;
    end else begin
      perf_ops_q       <= perf_ops_d;
      perf_shift_cyc_q <= perf_shift_cyc_d;
    end
  end

  assign perf_ops       = perf_ops_q;
  assign perf_shift_cyc = perf_shift_cyc_q;
`endif
endmodule
